// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the count_ctrl block: controller state encoding and
// the largest value a BCD digit may hold.
// No ports (package).
// ---------------------------------------------------------------------------
package cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } cnt_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/count_ctrl_if.sv
// ---------------------------------------------------------------------------
// count_ctrl_if
// Groups the command inputs and the count/status outputs of count_ctrl.
//   start, stop, clear : one-cycle command pulses from the master
//   wrap               : roll-over (1) or halt (0) at the terminal count
//   ones, tens         : BCD digits of the count
//   tick               : one-cycle pulse coincident with new digit values
//   running, done      : status flags
//   state              : controller state, exported for observation
//
// Handshake: commands are plain one-cycle pulses with no ready/ack. A command
// is taken on the rising clk edge at which it is sampled high; if several are
// high in the same cycle, clear wins over stop, and stop wins over start.
// Commands that do not apply to the current state are dropped silently.
// ---------------------------------------------------------------------------
interface count_ctrl_if;
    import cnt_pkg::*;

    logic       start;
    logic       stop;
    logic       clear;
    logic       wrap;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tick;
    logic       running;
    logic       done;
    cnt_state_e state;

    modport master (
        output start, stop, clear, wrap,
        input  ones, tens, tick, running, done, state
    );

    modport slave (
        input  start, stop, clear, wrap,
        output ones, tens, tick, running, done, state
    );

endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// 10-bit prescaler. Counts 0..DIV-1 while enabled and holds otherwise.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   en    : advance the prescaler this cycle
//   clr   : synchronous zero (wins over en)
//   pulse : combinational, high when enabled and at DIV-1 (the step edge)
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam logic [9:0] LAST = 10'(DIV - 1);

    logic [9:0] r_pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (clr) begin
            r_pcnt <= '0;
        end else if (en) begin
            if (r_pcnt == LAST) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 10'd1;
            end
        end
    end

    assign pulse = en && (r_pcnt == LAST);

endmodule

// File: rtl/count_ctrl.sv
// ---------------------------------------------------------------------------
// count_ctrl
// Two-digit BCD up-counter with run/pause/clear control. Every DIV clk cycles
// in RUN the count advances by one. At the terminal count LIM_TENS:LIM_ONES
// it either rolls over to 00 (wrap=1) or halts in DONE (wrap=0).
//   clk  : system clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : count_ctrl_if.slave (commands in, digits/status/state out)
// ---------------------------------------------------------------------------
module count_ctrl #(
    parameter int DIV      = 50,
    parameter int LIM_TENS = 9,
    parameter int LIM_ONES = 9
) (
    input  logic         clk,
    input  logic         rst,
    count_ctrl_if.slave  bus
);
    import cnt_pkg::*;

    localparam logic [3:0] LIM_T = 4'(LIM_TENS);
    localparam logic [3:0] LIM_O = 4'(LIM_ONES);

    cnt_state_e r_state;
    cnt_state_e w_next_state;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_tick;
    logic       w_pre_en;
    logic       w_pulse;
    logic       w_step;
    logic       w_at_term;
    logic       w_reach_term;
    logic [3:0] w_next_ones;
    logic [3:0] w_next_tens;

    // The prescaler only advances in RUN on cycles with no stop/clear, so a
    // stop leaves it exactly where it was and a resume continues from there.
    assign w_pre_en = (r_state == ST_RUN) && !bus.clear && !bus.stop;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (w_pre_en),
        .clr   (bus.clear),
        .pulse (w_pulse)
    );

    // Next digit values for a step. At the terminal count the step rolls to
    // 00; otherwise ordinary BCD increment with carry into tens.
    always_comb begin
        w_next_ones = r_ones;
        w_next_tens = r_tens;
        w_at_term   = (r_tens == LIM_T) && (r_ones == LIM_O);
        if (w_at_term) begin
            w_next_ones = 4'd0;
            w_next_tens = 4'd0;
        end else if (r_ones >= BCD_MAX) begin
            w_next_ones = 4'd0;
            w_next_tens = (r_tens >= BCD_MAX) ? 4'd0 : r_tens + 4'd1;
        end else begin
            w_next_ones = r_ones + 4'd1;
        end
        w_reach_term = (w_next_tens == LIM_T) && (w_next_ones == LIM_O);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        if (bus.clear) begin
            w_next_state = ST_IDLE;
        end else if (bus.stop) begin
            if (r_state == ST_RUN) begin
                w_next_state = ST_PAUSE;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (bus.start) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pulse) begin
                        w_step = 1'b1;
                        // wrap is looked at only here, on the step edge.
                        if (w_reach_term && !bus.wrap) begin
                            w_next_state = ST_DONE;
                        end
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_step;
            if (bus.clear) begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
            end else if (w_step) begin
                r_ones <= w_next_ones;
                r_tens <= w_next_tens;
            end
        end
    end

    assign bus.ones    = r_ones;
    assign bus.tens    = r_tens;
    assign bus.tick    = r_tick;
    assign bus.running = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.state   = r_state;

endmodule

// File: tb/tb_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_ctrl
// Directed bench for count_ctrl with DIV=4. dut_a uses the default 99 limit,
// dut_b uses a 12 limit with wrap=0. Inputs change and outputs are sampled on
// the falling clk edge.
// ---------------------------------------------------------------------------
module tb_count_ctrl;
    import cnt_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    count_ctrl_if bus_a ();
    count_ctrl_if bus_b ();

    count_ctrl #(
        .DIV      (4),
        .LIM_TENS (9),
        .LIM_ONES (9)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    count_ctrl #(
        .DIV      (4),
        .LIM_TENS (1),
        .LIM_ONES (2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // checking task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a(input logic s, input logic p, input logic c);
        bus_a.start = s;
        bus_a.stop  = p;
        bus_a.clear = c;
        cyc(1);
        bus_a.start = 1'b0;
        bus_a.stop  = 1'b0;
        bus_a.clear = 1'b0;
    endtask

    task automatic pulse_b(input logic s, input logic p, input logic c);
        bus_b.start = s;
        bus_b.stop  = p;
        bus_b.clear = c;
        cyc(1);
        bus_b.start = 1'b0;
        bus_b.stop  = 1'b0;
        bus_b.clear = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_a.stop  = 1'b0;
        bus_a.clear = 1'b0;
        bus_a.wrap  = 1'b1;
        bus_b.start = 1'b0;
        bus_b.stop  = 1'b0;
        bus_b.clear = 1'b0;
        bus_b.wrap  = 1'b0;
        cyc(2);

        // reset state
        check("rst_ones",    32'(bus_a.ones),    32'd0);
        check("rst_tens",    32'(bus_a.tens),    32'd0);
        check("rst_tick",    32'(bus_a.tick),    32'd0);
        check("rst_running", 32'(bus_a.running), 32'd0);
        check("rst_done",    32'(bus_a.done),    32'd0);
        check("rst_state",   32'(bus_a.state),   32'(ST_IDLE));

        // start on the first edge after reset release
        rst = 1'b0;
        pulse_a(1'b1, 1'b0, 1'b0);
        check("start_running", 32'(bus_a.running), 32'd1);
        cyc(3);
        check("pre_step_ones", 32'(bus_a.ones), 32'd0);
        check("pre_step_tick", 32'(bus_a.tick), 32'd0);
        cyc(1);
        check("step1_ones", 32'(bus_a.ones), 32'd1);
        check("step1_tick", 32'(bus_a.tick), 32'd1);
        cyc(1);
        check("tick_drop", 32'(bus_a.tick), 32'd0);
        cyc(3);
        check("step2_ones", 32'(bus_a.ones), 32'd2);

        // 09 -> 10 carry
        cyc(28);
        check("c09_ones", 32'(bus_a.ones), 32'd9);
        check("c09_tens", 32'(bus_a.tens), 32'd0);
        cyc(4);
        check("c10_ones", 32'(bus_a.ones), 32'd0);
        check("c10_tens", 32'(bus_a.tens), 32'd1);
        check("c10_tick", 32'(bus_a.tick), 32'd1);
        cyc(1);
        check("c10_tick_drop", 32'(bus_a.tick), 32'd0);

        // 99 -> 00 with wrap=1
        cyc(355);
        check("c99_ones", 32'(bus_a.ones), 32'd9);
        check("c99_tens", 32'(bus_a.tens), 32'd9);
        cyc(4);
        check("wrap_ones",    32'(bus_a.ones),    32'd0);
        check("wrap_tens",    32'(bus_a.tens),    32'd0);
        check("wrap_running", 32'(bus_a.running), 32'd1);
        check("wrap_tick",    32'(bus_a.tick),    32'd1);

        // pause at ones=3 with prescaler at 2, resume
        cyc(12);
        check("p_ones3", 32'(bus_a.ones), 32'd3);
        cyc(2);
        pulse_a(1'b0, 1'b1, 1'b0);
        check("pause_state",   32'(bus_a.state),   32'(ST_PAUSE));
        check("pause_running", 32'(bus_a.running), 32'd0);
        cyc(10);
        check("pause_hold", 32'(bus_a.ones), 32'd3);
        pulse_a(1'b1, 1'b0, 1'b0);
        check("resume_running", 32'(bus_a.running), 32'd1);
        cyc(1);
        check("resume_ones3", 32'(bus_a.ones), 32'd3);
        cyc(1);
        check("resume_ones4", 32'(bus_a.ones), 32'd4);
        check("resume_tick",  32'(bus_a.tick), 32'd1);

        // start+stop+clear together: clear wins
        pulse_a(1'b1, 1'b1, 1'b1);
        check("all3_state", 32'(bus_a.state), 32'(ST_IDLE));
        check("all3_ones",  32'(bus_a.ones),  32'd0);
        check("all3_tick",  32'(bus_a.tick),  32'd0);

        // asynchronous reset mid-count
        pulse_a(1'b1, 1'b0, 1'b0);
        cyc(4);
        check("pre_rst_ones", 32'(bus_a.ones), 32'd1);
        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ones",    32'(bus_a.ones),    32'd0);
        check("arst_running", 32'(bus_a.running), 32'd0);
        check("arst_state",   32'(bus_a.state),   32'(ST_IDLE));
        cyc(1);
        rst = 1'b0;
        pulse_a(1'b1, 1'b0, 1'b0);
        check("post_rst_running", 32'(bus_a.running), 32'd1);
        cyc(4);
        check("post_rst_ones", 32'(bus_a.ones), 32'd1);
        check("post_rst_tens", 32'(bus_a.tens), 32'd0);
        pulse_a(1'b0, 1'b0, 1'b1);

        // dut_b: halt at 12 with wrap=0
        pulse_b(1'b1, 1'b0, 1'b0);
        check("b_running", 32'(bus_b.running), 32'd1);
        cyc(47);
        check("b11_ones", 32'(bus_b.ones), 32'd1);
        check("b11_tens", 32'(bus_b.tens), 32'd1);
        check("b11_done", 32'(bus_b.done), 32'd0);
        cyc(1);
        check("b12_ones",    32'(bus_b.ones),    32'd2);
        check("b12_tens",    32'(bus_b.tens),    32'd1);
        check("b12_done",    32'(bus_b.done),    32'd1);
        check("b12_running", 32'(bus_b.running), 32'd0);
        check("b12_tick",    32'(bus_b.tick),    32'd1);
        bus_b.wrap = 1'b1;
        pulse_b(1'b1, 1'b0, 1'b0);
        cyc(8);
        check("bdone_ones", 32'(bus_b.ones), 32'd2);
        check("bdone_tens", 32'(bus_b.tens), 32'd1);
        check("bdone_done", 32'(bus_b.done), 32'd1);
        check("bdone_tick", 32'(bus_b.tick), 32'd0);
        pulse_b(1'b0, 1'b0, 1'b1);
        check("bclr_ones",  32'(bus_b.ones),  32'd0);
        check("bclr_tens",  32'(bus_b.tens),  32'd0);
        check("bclr_state", 32'(bus_b.state), 32'(ST_IDLE));

        // stop beats start in RUN
        pulse_b(1'b1, 1'b0, 1'b0);
        cyc(1);
        pulse_b(1'b1, 1'b1, 1'b0);
        check("prio_state", 32'(bus_b.state), 32'(ST_PAUSE));
        pulse_b(1'b0, 1'b0, 1'b1);

        // report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
